mem_loader: RTL and testbench

//  Host-side initiator for the CPU's two external memory ports (instruction and data SRAM).

---
 rtl/mem_loader_pkg.sv | 41 ++++
 rtl/reg_arstn_en.sv | 30 +++
 rtl/mem_loader.sv | 243 ++++++++++++++++++++++++
 tb/tb_mem_loader.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// Purpose: shared command codes and FSM state encoding for the memory loader
// Latency: n/a (types and constants only)
// Backpressure: n/a
//
// The command codes are also used by the host model in the testbench, so the
// numeric values below are part of the host interface and must not change.
package mem_loader_pkg;

  localparam int ADDR_W = 32;

  // Host command opcodes carried on cmd_op.
  typedef enum logic [1:0] {
    OP_LOAD_IMEM = 2'd0,
    OP_LOAD_DMEM = 2'd1,
    OP_DUMP_DMEM = 2'd2,
    OP_RUN       = 2'd3
  } cmd_op_e;

  // IDLE is encoded as zero so the reset value of the state register is IDLE.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RD_OUT  = 3'd4,
    ST_RUN     = 3'd5
  } state_e;

  // State entered after accepting a command with a non-zero length.
  function automatic state_e first_state(input cmd_op_e op);
    state_e s;
    case (op)
      OP_LOAD_IMEM,
      OP_LOAD_DMEM: s = ST_WRITE;
      OP_DUMP_DMEM: s = ST_RD_REQ;
      default:      s = ST_RUN;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/reg_arstn_en.sv
// Purpose: generic register with load enable and asynchronous active-low reset
// Latency: 1 cycle from d to q when en is high
// Backpressure: none; holds q while en is low
//
// Ports:
//   clk    in  1  clock
//   arst_n in  1  asynchronous reset, active low (q <= RST_VAL)
//   en     in  1  load enable
//   d      in  W  next value
//   q      out W  registered value
module reg_arstn_en #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Purpose: host-side initiator that loads/dumps the CPU's external SRAM ports and runs the CPU
// Latency: 1-cycle writes per accepted word; 3 cycles per dumped word before out_valid; done 1 cycle after last beat
// Backpressure: cmd_ready only in IDLE; in_ready only while writing; out_data held until out_ready
//
// Ports:
//   clk, arst_n                         clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_op/
//     cmd_addr/cmd_len                  host command channel (len = words or cycles)
//   in_valid/in_ready/in_data           host write-data stream for loads
//   out_valid/out_ready/out_data        dump data stream back to the host
//   busy, done                          status: not-IDLE, one-cycle completion pulse
//   cpu_enable                          CPU run enable, high only while running
//   addr_ext/wen_ext/ren_ext/wdata_ext  instruction SRAM external port (write only)
//   addr_ext_2/wen_ext_2/ren_ext_2/
//     wdata_ext_2/rdata_ext_2           data SRAM external port
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 16,
  parameter int ADDR_STEP = 4
) (
  input  logic              clk,
  input  logic              arst_n,
  // command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  // write-data stream
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  // dump stream
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  // status
  output logic              busy,
  output logic              done,
  output logic              cpu_enable,
  // instruction memory external port
  output logic [ADDR_W-1:0] addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [DATA_W-1:0] wdata_ext,
  // data memory external port
  output logic [ADDR_W-1:0] addr_ext_2,
  output logic              wen_ext_2,
  output logic              ren_ext_2,
  output logic [DATA_W-1:0] wdata_ext_2,
  input  logic [DATA_W-1:0] rdata_ext_2
);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [2:0]        state_raw;
  state_e            state_q;
  state_e            state_d;
  logic [1:0]        op_raw;
  cmd_op_e           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [LEN_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  cnt_d;
  logic [DATA_W-1:0] out_q;
  logic              done_q;
  logic              done_d;

  // Strobes produced by the next-state logic.
  logic              cmd_fire;
  logic              in_fire;
  logic              out_fire;
  logic              last_beat;
  logic              addr_step;
  logic              cnt_dec;

  assign state_q = state_e'(state_raw);
  assign op_q    = cmd_op_e'(op_raw);

  reg_arstn_en #(.W(3)) u_state_reg (
    .clk    (clk),
    .arst_n (arst_n),
    .en     (1'b1),
    .d      (state_d),
    .q      (state_raw)
  );

  reg_arstn_en #(.W(2)) u_op_reg (
    .clk    (clk),
    .arst_n (arst_n),
    .en     (cmd_fire),
    .d      (cmd_op),
    .q      (op_raw)
  );

  reg_arstn_en #(.W(ADDR_W)) u_addr_reg (
    .clk    (clk),
    .arst_n (arst_n),
    .en     (cmd_fire | addr_step),
    .d      (addr_d),
    .q      (addr_q)
  );

  reg_arstn_en #(.W(LEN_W)) u_cnt_reg (
    .clk    (clk),
    .arst_n (arst_n),
    .en     (cmd_fire | cnt_dec),
    .d      (cnt_d),
    .q      (cnt_q)
  );

  // SRAM read data is valid in the cycle after the read request.
  reg_arstn_en #(.W(DATA_W)) u_out_reg (
    .clk    (clk),
    .arst_n (arst_n),
    .en     (state_q == ST_RD_WAIT),
    .d      (rdata_ext_2),
    .q      (out_q)
  );

  reg_arstn_en #(.W(1)) u_done_reg (
    .clk    (clk),
    .arst_n (arst_n),
    .en     (1'b1),
    .d      (done_d),
    .q      (done_q)
  );

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign cmd_ready = (state_q == ST_IDLE);
  assign in_ready  = (state_q == ST_WRITE);
  assign out_valid = (state_q == ST_RD_OUT);

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign in_fire   = in_valid  & in_ready;
  assign out_fire  = out_valid & out_ready;

  // cnt holds the number of beats still to go, including the current one.
  assign last_beat = (cnt_q == LEN_W'(1));

  // Address wraps modulo 2^32 by plain truncation.
  assign addr_d = cmd_fire ? cmd_addr : (addr_q + ADDR_W'(ADDR_STEP));
  assign cnt_d  = cmd_fire ? cmd_len  : (cnt_q - LEN_W'(1));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    addr_step = 1'b0;
    cnt_dec   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          // A zero-length command completes without leaving IDLE.
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = first_state(cmd_op_e'(cmd_op));
          end
        end
      end

      ST_WRITE: begin
        if (in_fire) begin
          addr_step = 1'b1;
          cnt_dec   = 1'b1;
          if (last_beat) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      ST_RD_REQ:  state_d = ST_RD_WAIT;

      ST_RD_WAIT: state_d = ST_RD_OUT;

      ST_RD_OUT: begin
        if (out_fire) begin
          addr_step = 1'b1;
          cnt_dec   = 1'b1;
          if (last_beat) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RD_REQ;
          end
        end
      end

      ST_RUN: begin
        // One enabled cycle per count; leave after the last one.
        cnt_dec = 1'b1;
        if (last_beat) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory port drive. Strobes are decoded from the state register (and the
  // live in_valid for writes), so an asynchronous reset drops them at once.
  // Address/data are forced to zero whenever the port is not in use.
  // ---------------------------------------------------------------------------
  logic wr_imem;
  logic wr_dmem;
  logic rd_dmem;

  assign wr_imem = in_fire & (op_q == OP_LOAD_IMEM);
  assign wr_dmem = in_fire & (op_q == OP_LOAD_DMEM);
  assign rd_dmem = (state_q == ST_RD_REQ);

  assign wen_ext     = wr_imem;
  assign ren_ext     = 1'b0;
  assign addr_ext    = wr_imem ? addr_q  : '0;
  assign wdata_ext   = wr_imem ? in_data : '0;

  assign wen_ext_2   = wr_dmem;
  assign ren_ext_2   = rd_dmem;
  assign addr_ext_2  = (wr_dmem | rd_dmem) ? addr_q : '0;
  assign wdata_ext_2 = wr_dmem ? in_data : '0;

  // ---------------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------------
  assign out_data   = out_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign cpu_enable = (state_q == ST_RUN);

endmodule

// File: tb/tb_mem_loader.sv
// Purpose: self-checking bench for mem_loader with an SRAM model and scoreboard
// Latency: n/a
// Backpressure: host model stalls out_ready and bubbles in_valid
module tb_mem_loader;
  import mem_loader_pkg::*;

  logic        clk;
  logic        arst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
  logic        done;
  logic        cpu_enable;
  logic [31:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [31:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [31:0] wdata_ext_2;
  logic [31:0] rdata_ext_2;

  mem_loader dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .done        (done),
    .cpu_enable  (cpu_enable),
    .addr_ext    (addr_ext),
    .wen_ext     (wen_ext),
    .ren_ext     (ren_ext),
    .wdata_ext   (wdata_ext),
    .addr_ext_2  (addr_ext_2),
    .wen_ext_2   (wen_ext_2),
    .ren_ext_2   (ren_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .rdata_ext_2 (rdata_ext_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected or never seen", name);
  endtask

  // ---------------------------------------------------------------------------
  // Data SRAM model: 1-cycle read latency.
  // ---------------------------------------------------------------------------
  logic [31:0] dmem [logic [31:0]];

  always @(posedge clk) begin
    if (wen_ext_2) dmem[addr_ext_2] = wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= dmem.exists(addr_ext_2) ? dmem[addr_ext_2] : 32'hDEAD_BEEF;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard queues, filled by stimulus, drained by the monitor.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        mem;   // 0 = instruction memory, 1 = data memory
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_wr [$];
  logic [31:0] exp_rd [$];
  logic [31:0] exp_out[$];

  int en_cnt   = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (arst_n) begin
      if (cpu_enable) en_cnt++;
      if (busy)       busy_cnt++;
      if (done)       done_cnt++;
    end
  end

  always @(negedge clk) begin
    wr_t e;
    if (arst_n) begin
      chk("ren_ext_tied_low", ren_ext, 1'b0);
      chk("enable_excl_mem", cpu_enable & (wen_ext | wen_ext_2 | ren_ext_2), 1'b0);
      if (wen_ext) begin
        if (exp_wr.size() == 0) fail("imem_write_unexpected");
        else begin
          e = exp_wr.pop_front();
          chk("imem_write", {1'b0, addr_ext, wdata_ext}, e);
        end
      end
      if (wen_ext_2) begin
        if (exp_wr.size() == 0) fail("dmem_write_unexpected");
        else begin
          e = exp_wr.pop_front();
          chk("dmem_write", {1'b1, addr_ext_2, wdata_ext_2}, e);
        end
      end
      if (ren_ext_2) begin
        if (exp_rd.size() == 0) fail("dmem_read_unexpected");
        else chk("dmem_read_addr", addr_ext_2, exp_rd.pop_front());
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) fail("dump_word_unexpected");
        else chk("dump_word", out_data, exp_out.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Host driver tasks. Inputs change 1 time unit after the rising edge; ready
  // is sampled on the falling edge before the edge that would transfer.
  // ---------------------------------------------------------------------------
  logic acc_done;

  task automatic send_cmd(input cmd_op_e op, input logic [31:0] addr, input logic [15:0] len);
    logic acc;
    int   n;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_len   = len;
    n = 0;
    do begin
      @(negedge clk);
      acc      = cmd_ready;
      acc_done = done;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 300);
    cmd_valid = 1'b0;
    if (!acc) fail("cmd_accept_timeout");
  endtask

  task automatic put_word(input logic [31:0] w, input int gap);
    logic acc;
    int   n;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 300);
    in_valid = 1'b0;
    if (!acc) fail("in_accept_timeout");
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 300);
    chk(name, done, 1'b1);
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    int          e0, d0, b0;
    logic        ok;
    logic [31:0] first;
    int          n;

    arst_n    = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_addr  = '0;
    cmd_len   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    acc_done  = 1'b0;

    // Reset state.
    #12;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_status", {busy, done, cpu_enable, out_valid, in_ready}, 5'b0);
    chk("rst_strobes", {wen_ext, ren_ext, wen_ext_2, ren_ext_2}, 4'b0);
    chk("rst_buses", {addr_ext, addr_ext_2, out_data}, 96'b0);
    #11 arst_n = 1'b1;
    @(posedge clk);
    #1;

    // LOAD_IMEM addr 0, three words, back to back.
    e0 = en_cnt;
    exp_wr.push_back({1'b0, 32'h0000_0000, 32'hAAAA_0001});
    exp_wr.push_back({1'b0, 32'h0000_0004, 32'hBBBB_0002});
    exp_wr.push_back({1'b0, 32'h0000_0008, 32'hCCCC_0003});
    send_cmd(OP_LOAD_IMEM, 32'h0, 16'd3);
    put_word(32'hAAAA_0001, 0);
    put_word(32'hBBBB_0002, 0);
    put_word(32'hCCCC_0003, 0);
    @(negedge clk);
    chk("load_imem_done_next_cycle", {done, busy}, 2'b10);
    chk("load_imem_no_enable", en_cnt - e0, 0);
    @(posedge clk);
    #1;

    // LOAD_DMEM 0x10 x2, then dump it back with a 5-cycle stall.
    exp_wr.push_back({1'b1, 32'h0000_0010, 32'h1234_5678});
    exp_wr.push_back({1'b1, 32'h0000_0014, 32'h9ABC_DEF0});
    send_cmd(OP_LOAD_DMEM, 32'h10, 16'd2);
    put_word(32'h1234_5678, 0);
    put_word(32'h9ABC_DEF0, 0);
    wait_done("load_dmem_done");

    exp_rd.push_back(32'h10);
    exp_rd.push_back(32'h14);
    exp_out.push_back(32'h1234_5678);
    exp_out.push_back(32'h9ABC_DEF0);
    send_cmd(OP_DUMP_DMEM, 32'h10, 16'd2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    first = out_data;
    chk("dump_first_word", {out_valid, first}, {1'b1, 32'h1234_5678});
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!out_valid || out_data !== 32'h1234_5678) ok = 1'b0;
    end
    chk("dump_stall_stable", ok, 1'b1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done("dump_done");
    out_ready = 1'b0;

    // RUN for 7 cycles.
    e0 = en_cnt;
    d0 = done_cnt;
    b0 = busy_cnt;
    send_cmd(OP_RUN, 32'h0, 16'd7);
    ok = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (!cpu_enable) ok = 1'b0;
    end
    chk("run_enable_7_cycles", ok, 1'b1);
    @(negedge clk);
    chk("run_end_done", {cpu_enable, done}, 2'b01);
    repeat (3) @(negedge clk);
    #1;
    chk("run_enable_count", en_cnt - e0, 7);
    chk("run_single_done", done_cnt - d0, 1);
    chk("run_busy_min", (busy_cnt - b0) >= 7, 1'b1);
    @(posedge clk);
    #1;

    // Zero-length command for every op.
    for (int i = 0; i < 4; i++) begin
      e0 = en_cnt;
      send_cmd(cmd_op_e'(i[1:0]), 32'h20, 16'd0);
      @(negedge clk);
      chk("len0_done", {done, busy, cmd_ready}, 3'b101);
      @(posedge clk);
      #1;
      chk("len0_no_enable", en_cnt - e0, 0);
    end

    // Reset during word 2 of a 4-word load.
    exp_wr.push_back({1'b0, 32'h0000_0100, 32'h5555_0000});
    send_cmd(OP_LOAD_IMEM, 32'h100, 16'd4);
    put_word(32'h5555_0000, 0);
    in_valid = 1'b1;
    in_data  = 32'h5555_0001;
    #2;
    chk("midload_wen_high", {wen_ext, addr_ext}, {1'b1, 32'h104});
    arst_n = 1'b0;
    #1;
    chk("midload_reset_async", {wen_ext, busy, cmd_ready, cpu_enable}, 4'b0010);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    @(negedge clk);
    chk("midload_idle_after", {cmd_ready, busy, done}, 3'b100);
    @(posedge clk);
    #1;

    // Reset in the middle of a run.
    send_cmd(OP_RUN, 32'h0, 16'd20);
    repeat (3) @(negedge clk);
    chk("midrun_enable_high", cpu_enable, 1'b1);
    #2;
    arst_n = 1'b0;
    #1;
    chk("midrun_reset_async", {cpu_enable, busy, cmd_ready}, 3'b001);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    @(negedge clk);
    chk("midrun_idle_after", {cmd_ready, busy, cpu_enable}, 3'b100);
    @(posedge clk);
    #1;

    // Bubbly write stream with a second command offered while busy.
    exp_wr.push_back({1'b1, 32'h0000_0040, 32'hE000_0000});
    exp_wr.push_back({1'b1, 32'h0000_0044, 32'hE000_0001});
    exp_wr.push_back({1'b1, 32'h0000_0048, 32'hE000_0002});
    send_cmd(OP_LOAD_DMEM, 32'h40, 16'd3);
    fork
      begin
        put_word(32'hE000_0000, 2);
        put_word(32'hE000_0001, 2);
        put_word(32'hE000_0002, 2);
      end
      begin
        send_cmd(OP_RUN, 32'h0, 16'd2);
      end
    join
    chk("queued_cmd_after_done", acc_done, 1'b1);
    wait_done("queued_run_done");

    // in_valid while idle must not write.
    in_valid = 1'b1;
    in_data  = 32'hBAD0_BAD0;
    ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (in_ready) ok = 1'b0;
    end
    chk("idle_in_ignored", ok, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // Address wraps past 2^32.
    exp_wr.push_back({1'b0, 32'hFFFF_FFFC, 32'h0BAD_F00D});
    exp_wr.push_back({1'b0, 32'h0000_0000, 32'hC0DE_CAFE});
    send_cmd(OP_LOAD_IMEM, 32'hFFFF_FFFC, 16'd2);
    put_word(32'h0BAD_F00D, 1);
    put_word(32'hC0DE_CAFE, 0);
    wait_done("wrap_done");

    repeat (3) @(posedge clk);
    #1;
    chk("sb_writes_drained", exp_wr.size(), 0);
    chk("sb_reads_drained", exp_rd.size(), 0);
    chk("sb_dump_drained", exp_out.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
